// File: rtl/seq_countones.sv
// -----------------------------------------------------------------------------
// seq_countones
// Multi-cycle population count. A WIDTH-bit word is accepted over a
// valid/ready handshake, its set bits are summed CHUNK bits per cycle
// (LSB chunk first), and the count plus zero/onehot/onehot0 flags are
// presented over a second valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     in_data is valid
//   in_ready     block can accept a word (IDLE and out of reset)
//   in_data      WIDTH-bit word to count
//   out_valid    result is valid (DONE)
//   out_ready    consumer accepts the result
//   out_count    number of 1 bits in the accepted word
//   out_zero     out_count == 0
//   out_onehot   out_count == 1
//   out_onehot0  out_count <= 1
// -----------------------------------------------------------------------------
module seq_countones #(
   parameter int WIDTH = 128,
   parameter int CHUNK = 16,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_count,
   output logic             out_zero,
   output logic             out_onehot,
   output logic             out_onehot0
);

   localparam int NCHUNK = WIDTH / CHUNK;
   // Keep the chunk index at least one bit wide when a single chunk covers the word.
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [WIDTH-1:0]  r_shift;
   logic [CW-1:0]     r_acc;
   logic [IW-1:0]     r_idx;
   logic              w_accept;
   logic              w_last;
   logic [CW-1:0]     w_chunk_pc;

   // Popcount of one chunk, zero-extended to the count width.
   function automatic logic [CW-1:0] chunk_popcount(input logic [CHUNK-1:0] v);
      logic [CW-1:0] s;
      s = '0;
      for (int i = 0; i < CHUNK; i++) begin
         s = s + CW'(v[i]);
      end
      return s;
   endfunction

   // in_ready is gated by rst_n so it reads 0 while reset is held, even though
   // the state register already sits in IDLE.
   assign in_ready   = rst_n & (r_state == IDLE);
   assign w_accept   = in_valid & in_ready;
   assign w_last     = (r_idx == IW'(NCHUNK - 1));
   assign w_chunk_pc = chunk_popcount(r_shift[CHUNK-1:0]);

   // Result outputs come straight from the accumulator register.
   assign out_valid   = (r_state == DONE);
   assign out_count   = r_acc;
   assign out_zero    = (r_acc == CW'(0));
   assign out_onehot  = (r_acc == CW'(1));
   assign out_onehot0 = (r_acc <= CW'(1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next_state = BUSY;
            else          w_next_state = IDLE;
         end
         BUSY: begin
            if (w_last) w_next_state = DONE;
            else        w_next_state = BUSY;
         end
         DONE: begin
            if (out_ready) w_next_state = IDLE;
            else           w_next_state = DONE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Datapath: capture on accept, then add and shift one chunk per BUSY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_shift <= in_data;
                  r_acc   <= '0;
                  r_idx   <= '0;
               end else begin
                  r_shift <= r_shift;
                  r_acc   <= r_acc;
                  r_idx   <= r_idx;
               end
            end
            BUSY: begin
               r_acc   <= r_acc + w_chunk_pc;
               r_shift <= r_shift >> CHUNK;
               // The index returns to zero only as the word completes.
               if (w_last) r_idx <= '0;
               else        r_idx <= r_idx + IW'(1'b1);
            end
            default: begin
               r_shift <= r_shift;
               r_acc   <= r_acc;
               r_idx   <= r_idx;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_countones.sv
module tb_seq_countones;

   typedef struct {
      logic [7:0] cnt;
      logic       z;
      logic       oh;
      logic       oh0;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [7:0]    out_count;
   logic          out_zero, out_onehot, out_onehot0;

   logic          in_valid2 = 1'b0;
   logic          in_ready2;
   logic [127:0]  in_data2 = '0;
   logic          out_valid2;
   logic          out_ready2 = 1'b1;
   logic [7:0]    out_count2;
   logic          out_zero2, out_onehot2, out_onehot02;

   int n_vec = 0;
   int n_err = 0;
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   seq_countones #(.WIDTH(128), .CHUNK(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
      .out_zero(out_zero), .out_onehot(out_onehot), .out_onehot0(out_onehot0)
   );

   seq_countones #(.WIDTH(128), .CHUNK(128)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_count(out_count2),
      .out_zero(out_zero2), .out_onehot(out_onehot2), .out_onehot0(out_onehot02)
   );

   function automatic exp_t mk(input logic [7:0] c, input logic z, input logic oh, input logic oh0);
      exp_t e;
      e.cnt = c; e.z = z; e.oh = oh; e.oh0 = oh0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s", name);
   endtask

   // Monitor for the CHUNK=16 instance: pops on every output handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q1.size() == 0) begin
            fail_now("mon1 unexpected result");
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("mon1 count",   out_count,   e.cnt);
            chk("mon1 zero",    out_zero,    e.z);
            chk("mon1 onehot",  out_onehot,  e.oh);
            chk("mon1 onehot0", out_onehot0, e.oh0);
         end
      end
   end

   // Monitor for the CHUNK=128 instance.
   always @(negedge clk) begin
      if (rst_n && out_valid2 && out_ready2) begin
         if (q2.size() == 0) begin
            fail_now("mon2 unexpected result");
         end else begin
            exp_t e;
            e = q2.pop_front();
            chk("mon2 count",   out_count2,   e.cnt);
            chk("mon2 zero",    out_zero2,    e.z);
            chk("mon2 onehot",  out_onehot2,  e.oh);
            chk("mon2 onehot0", out_onehot02, e.oh0);
         end
      end
   end

   task automatic wait_ready(input string name);
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) fail_now({name, " timeout waiting for in_ready"});
   endtask

   task automatic send1(input logic [127:0] d);
      wait_ready("send1");
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = ~d;
   endtask

   // Checks handshake timing for cycles 1..10 after acceptance with out_ready=1.
   task automatic latency_check(input string name);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk({name, " out_valid"}, out_valid, (k == 9));
         chk({name, " in_ready"},  in_ready,  (k == 10));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values while rst_n is held low.
      #3;
      chk("rst out_valid",   out_valid,   1'b0);
      chk("rst out_count",   out_count,   8'd0);
      chk("rst out_zero",    out_zero,    1'b1);
      chk("rst out_onehot",  out_onehot,  1'b0);
      chk("rst out_onehot0", out_onehot0, 1'b1);
      chk("rst in_ready",    in_ready,    1'b0);
      #19 rst_n = 1'b1;
      #1 chk("post-rst in_ready", in_ready, 1'b1);

      // Zero word.
      q1.push_back(mk(8'd0, 1'b1, 1'b0, 1'b1));
      send1(128'd0);
      latency_check("zero");

      // All ones.
      q1.push_back(mk(8'd128, 1'b0, 1'b0, 1'b0));
      send1({128{1'b1}});
      latency_check("ones");

      // Last-chunk then first-chunk single bits, back-to-back.
      q1.push_back(mk(8'd1, 1'b0, 1'b1, 1'b1));
      q1.push_back(mk(8'd1, 1'b0, 1'b1, 1'b1));
      send1(128'h8000_0000_0000_0000_0000_0000_0000_0000);
      send1(128'h1);
      wait_ready("b2b drain");

      // Backpressure: result held while out_ready is low, second word ignored.
      out_ready = 1'b0;
      q1.push_back(mk(8'd7, 1'b0, 1'b0, 1'b0));
      send1(128'h3C7);
      begin
         int t;
         t = 0;
         while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (!out_valid) fail_now("hold timeout waiting for out_valid");
      end
      in_valid = 1'b1;
      in_data  = 128'h3;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold out_valid", out_valid, 1'b1);
         chk("hold out_count", out_count, 8'd7);
         chk("hold in_ready",  in_ready,  1'b0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      q1.push_back(mk(8'd2, 1'b0, 1'b0, 1'b0));
      wait_ready("hold release");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_ready("hold drain");

      // Reset in the middle of BUSY discards the word.
      send1(128'hFFFF_0000_0000_0000_0000_0000_0000_0000);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst out_valid", out_valid, 1'b0);
      chk("midrst out_count", out_count, 8'd0);
      chk("midrst out_zero",  out_zero,  1'b1);
      chk("midrst in_ready",  in_ready,  1'b0);
      #3 rst_n = 1'b1;
      #1;
      chk("midrst release in_ready",  in_ready,  1'b1);
      chk("midrst release out_valid", out_valid, 1'b0);
      q1.push_back(mk(8'd2, 1'b0, 1'b0, 1'b0));
      send1(128'h5);
      wait_ready("post-rst drain");

      // Single-chunk instance: one BUSY cycle.
      q2.push_back(mk(8'd2, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      chk("c128 in_ready", in_ready2, 1'b1);
      in_valid2 = 1'b1;
      in_data2  = 128'h8000_0001;
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      in_data2  = '0;
      @(negedge clk);
      chk("c128 cycle1 out_valid", out_valid2, 1'b0);
      @(negedge clk);
      chk("c128 cycle2 out_valid", out_valid2, 1'b1);

      repeat (3) @(negedge clk);
      chk("q1 empty", q1.size(), 0);
      chk("q2 empty", q2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
